// File: rtl/module_control.sv
// module_control: keypad-driven operand capture and sequencing for an external multiplier.
// Ports:
//   clk, rst (async, active-low)
//   key_valid, key_code[3:0]   keypad strobe and code (0-9 digit, E enter, F clear)
//   mult_done, mult_p[2N-1:0]  multiplier completion strobe and product
//   a, b [N-1:0]               registered operands
//   mult_init                  one-cycle multiplier start
//   load_a, load_b, load_m     one-cycle display-update pulses
//   m [2N-1:0]                 registered result
//   busy                       high while the multiplier runs (START, WAIT)
//   err                        sticky timeout flag
// Optional feature: define CTRL_TIMEOUT_EN to abort WAIT after TIMEOUT cycles and raise err.
module module_control #(
  parameter int N = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [3:0]     key_code,
  input  logic           mult_done,
  input  logic [2*N-1:0] mult_p,
  output logic [N-1:0]   a,
  output logic [N-1:0]   b,
  output logic           mult_init,
  output logic           load_a,
  output logic           load_b,
  output logic           load_m,
  output logic [2*N-1:0] m,
  output logic           busy,
  output logic           err
);
  typedef enum logic [2:0] {GET_A, GET_B, READY, START, WAIT, SHOW} state_t;
  state_t state;
  logic is_digit, is_enter, is_clear;
  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_enter = key_valid && (key_code == 4'hE);
  // clear must not abandon a running multiplication
  assign is_clear = key_valid && (key_code == 4'hF) && (state != START) && (state != WAIT);
`ifdef CTRL_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  logic timeout;
  assign timeout = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= GET_A;
      a         <= '0;
      b         <= '0;
      m         <= '0;
      mult_init <= 1'b0;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      load_m    <= 1'b0;
      busy      <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      err       <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      mult_init <= 1'b0;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      load_m    <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      // counter is zero on WAIT entry because it is held at zero elsewhere
      cnt       <= (state == WAIT) ? cnt + 1'b1 : '0;
`endif
      if (is_clear) begin
        a     <= '0;
        b     <= '0;
        m     <= '0;
        state <= GET_A;
`ifdef CTRL_TIMEOUT_EN
        err   <= 1'b0;
`endif
      end else begin
        case (state)
          GET_A: if (is_digit) begin
            a      <= N'(key_code);
            load_a <= 1'b1;
            state  <= GET_B;
          end
          GET_B: if (is_digit) begin
            b      <= N'(key_code);
            load_b <= 1'b1;
            state  <= READY;
          end
          READY: if (is_enter) begin
            mult_init <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
          START: state <= WAIT;
          WAIT: begin
            // a simultaneous key is simply dropped; done always wins
            if (mult_done) begin
              m      <= mult_p;
              load_m <= 1'b1;
              busy   <= 1'b0;
              state  <= SHOW;
            end
`ifdef CTRL_TIMEOUT_EN
            else if (timeout) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= GET_A;
            end
`endif
          end
          SHOW: state <= GET_A;
          default: state <= GET_A;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_module_control.sv
// tb_module_control: scoreboard bench for module_control with a fixed-latency multiplier model.
module tb_module_control;
  localparam int N = 4;
  localparam int TIMEOUT = 32;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic mult_done_m = 1'b0;
  logic mult_done_t = 1'b0;
  logic [2*N-1:0] p_m = '0;
  logic [2*N-1:0] p_t = '0;
  logic [2*N-1:0] mdl_prod = '0;
  logic mult_done;
  logic [2*N-1:0] mult_p;
  logic [N-1:0] a, b;
  logic mult_init, load_a, load_b, load_m, busy, err;
  logic [2*N-1:0] m;
  int checks = 0;
  int errors = 0;
  int n_init = 0;
  int cd = 0;
  bit mdl_en = 1'b1;
  logic [2*N-1:0] exp_q[$];

  assign mult_done = mult_done_m | mult_done_t;
  assign mult_p = mult_done_t ? p_t : p_m;

  module_control #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .mult_done(mult_done), .mult_p(mult_p), .a(a), .b(b), .mult_init(mult_init),
    .load_a(load_a), .load_b(load_b), .load_m(load_m), .m(m), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // multiplier model: answers mdl_prod LAT cycles after a sampled mult_init
  always @(negedge clk) begin
    mult_done_m = 1'b0;
    if (mult_init) n_init++;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mult_done_m = 1'b1;
        p_m = mdl_prod;
      end
    end
    if (mdl_en && mult_init) cd = LAT;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code = k;
    tick();
    key_valid = 1'b0;
    key_code = 4'h0;
  endtask

  task automatic wait_load_m(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (load_m) begin
        cyc = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  function automatic logic [2*N-1:0] pop_exp();
    return (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
  endfunction

  task automatic test_reset();
    logic [2*N-1:0] e;
    #1;
    checks++; if ({a, b, m, mult_init, load_a, load_b, load_m, busy, err} !== '0) begin errors++; $display("FAIL reset_initial got %0h want 0", {a, b, m, mult_init, load_a, load_b, load_m, busy, err}); end
    key(4'h5);
    checks++; if ({a, b, m, mult_init, load_a, load_b, load_m, busy, err} !== '0) begin errors++; $display("FAIL reset_key_ignored got %0h want 0", {a, b, m, mult_init, load_a, load_b, load_m, busy, err}); end
    rst = 1'b1;
    tick();
    checks++; if ({a, b, m, mult_init, load_a, load_b, load_m, busy, err} !== '0) begin errors++; $display("FAIL reset_release got %0h want 0", {a, b, m, mult_init, load_a, load_b, load_m, busy, err}); end
    e = '0;
    checks++; if (exp_q.size() != 0 || m !== e) begin errors++; $display("FAIL reset_m got %0h want %0h", m, e); end
  endtask

  task automatic test_ops();
    int cyc;
    bit bok;
    mdl_prod = 8'd81;
    key(4'h9); key(4'h9); key(4'hE);
    exp_q.push_back(8'h51);
    wait_load_m(cyc, bok);
    checks++; if (cyc != LAT + 1) begin errors++; $display("FAIL ops99_latency got %0d want %0d", cyc, LAT + 1); end
    checks++; begin logic [2*N-1:0] e; e = pop_exp(); if (m !== e) begin errors++; $display("FAIL ops99_m got %0h want %0h", m, e); end end
    tick();
    mdl_prod = 8'd0;
    key(4'h2); key(4'h0); key(4'hE);
    exp_q.push_back(8'h00);
    wait_load_m(cyc, bok);
    checks++; begin logic [2*N-1:0] e; e = pop_exp(); if (m !== e) begin errors++; $display("FAIL ops20_m got %0h want %0h", m, e); end end
    checks++; if (a !== 4'd2 || b !== 4'd0) begin errors++; $display("FAIL ops20_ab got %0h/%0h want 2/0", a, b); end
    tick();
  endtask

  task automatic test_basic();
    int cyc, c0;
    bit bok;
    c0 = n_init;
    mdl_prod = 8'd15;
    key(4'h3);
    checks++; if (a !== 4'd3 || load_a !== 1'b1) begin errors++; $display("FAIL basic_load_a got a=%0h load_a=%0b want a=3 load_a=1", a, load_a); end
    tick();
    checks++; if (load_a !== 1'b0) begin errors++; $display("FAIL basic_load_a_pulse got %0b want 0", load_a); end
    key(4'h5);
    checks++; if (b !== 4'd5 || load_b !== 1'b1) begin errors++; $display("FAIL basic_load_b got b=%0h load_b=%0b want b=5 load_b=1", b, load_b); end
    key(4'hE);
    exp_q.push_back(8'd15);
    checks++; if (mult_init !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_start got init=%0b busy=%0b want 1/1", mult_init, busy); end
    wait_load_m(cyc, bok);
    checks++; if (cyc != LAT + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, LAT + 1); end
    checks++; if (!bok) begin errors++; $display("FAIL basic_busy got 0 want 1 during WAIT"); end
    checks++; begin logic [2*N-1:0] e; e = pop_exp(); if (m !== e) begin errors++; $display("FAIL basic_m got %0h want %0h", m, e); end end
    checks++; if (n_init - c0 != 1) begin errors++; $display("FAIL basic_init_count got %0d want 1", n_init - c0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_show got %0b want 0", busy); end
    tick();
    checks++; if (load_m !== 1'b0 || m !== 8'd15 || a !== 4'd3) begin errors++; $display("FAIL basic_hold got load_m=%0b m=%0h a=%0h want 0/f/3", load_m, m, a); end
  endtask

  task automatic test_clear();
    int c0;
    c0 = n_init;
    key(4'h4);
    checks++; if (a !== 4'd4) begin errors++; $display("FAIL clear_a4 got %0h want 4", a); end
    key(4'hE);
    checks++; if (mult_init !== 1'b0) begin errors++; $display("FAIL clear_enter_getb got %0b want 0", mult_init); end
    key(4'hF);
    checks++; if ({a, b, m} !== '0 || {load_a, load_b, load_m} !== 3'b0) begin errors++; $display("FAIL clear_zero got abm=%0h loads=%0b want 0/0", {a, b, m}, {load_a, load_b, load_m}); end
    key(4'hE); key(4'hB);
    checks++; if ({a, b, load_a, load_b, mult_init} !== '0) begin errors++; $display("FAIL clear_ignored got %0h want 0", {a, b, load_a, load_b, mult_init}); end
    key(4'h1);
    checks++; if (load_a !== 1'b1 || a !== 4'd1) begin errors++; $display("FAIL clear_get_a got load_a=%0b a=%0h want 1/1", load_a, a); end
    checks++; if (n_init != c0) begin errors++; $display("FAIL clear_no_init got %0d want %0d", n_init, c0); end
    key(4'hF);
  endtask

  task automatic test_wait_keys();
    int cyc;
    bit bok;
    mdl_prod = 8'd42;
    key(4'h6); key(4'h7); key(4'hE);
    exp_q.push_back(8'd42);
    key(4'hF); key(4'h1);
    wait_load_m(cyc, bok);
    checks++; if (cyc != LAT - 1) begin errors++; $display("FAIL wait_latency got %0d want %0d", cyc, LAT - 1); end
    checks++; begin logic [2*N-1:0] e; e = pop_exp(); if (m !== e) begin errors++; $display("FAIL wait_m got %0h want %0h", m, e); end end
    checks++; if (a !== 4'd6 || b !== 4'd7) begin errors++; $display("FAIL wait_ab got %0h/%0h want 6/7", a, b); end
    tick();
  endtask

  task automatic test_back_to_back();
    mdl_en = 1'b0;
    mult_done_t = 1'b1; p_t = 8'hAA;
    tick();
    mult_done_t = 1'b0;
    checks++; if (load_m !== 1'b0 || m !== 8'd42) begin errors++; $display("FAIL stray_done got load_m=%0b m=%0h want 0/2a", load_m, m); end
    key(4'h2); key(4'h3); key(4'hE);
    exp_q.push_back(8'd6);
    tick(); tick();
    key_valid = 1'b1; key_code = 4'h5; mult_done_t = 1'b1; p_t = 8'd6;
    tick();
    key_valid = 1'b0; mult_done_t = 1'b0;
    checks++; begin logic [2*N-1:0] e; e = pop_exp(); if (load_m !== 1'b1 || m !== e) begin errors++; $display("FAIL same_cycle_done got load_m=%0b m=%0h want 1/%0h", load_m, m, e); end end
    checks++; if (a !== 4'd2 || load_a !== 1'b0) begin errors++; $display("FAIL same_cycle_key got a=%0h load_a=%0b want 2/0", a, load_a); end
    key(4'hF);
    checks++; if ({a, b, m} !== '0 || {load_a, load_b, load_m} !== 3'b0) begin errors++; $display("FAIL clear_in_show got abm=%0h loads=%0b want 0/0", {a, b, m}, {load_a, load_b, load_m}); end
    key(4'h7);
    checks++; if (load_a !== 1'b1 || a !== 4'd7) begin errors++; $display("FAIL show_to_get_a got load_a=%0b a=%0h want 1/7", load_a, a); end
    key(4'hF);
    mdl_en = 1'b1;
  endtask

  task automatic test_reset_wait();
    int c1;
    mdl_en = 1'b0;
    key(4'h5); key(4'h5); key(4'hE);
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy got %0b want 1", busy); end
    #2 rst = 1'b0;
    #1;
    c1 = n_init;
    checks++; if ({a, b, m, mult_init, load_a, load_b, load_m, busy, err} !== '0) begin errors++; $display("FAIL rw_async got %0h want 0", {a, b, m, mult_init, load_a, load_b, load_m, busy, err}); end
    tick();
    rst = 1'b1;
    tick();
    mult_done_t = 1'b1; p_t = 8'd25;
    tick();
    mult_done_t = 1'b0;
    tick();
    checks++; if (m !== 8'd0 || load_m !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rw_late_done got m=%0h load_m=%0b busy=%0b want 0/0/0", m, load_m, busy); end
    checks++; if (n_init != c1) begin errors++; $display("FAIL rw_no_init got %0d want %0d", n_init, c1); end
    key(4'h8);
    checks++; if (load_a !== 1'b1 || a !== 4'd8) begin errors++; $display("FAIL rw_get_a got load_a=%0b a=%0h want 1/8", load_a, a); end
    key(4'hF);
    mdl_en = 1'b1;
  endtask

`ifdef CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, hit;
    bit bok, saw_load_m;
    mdl_prod = 8'd24;
    key(4'h4); key(4'h6); key(4'hE);
    exp_q.push_back(8'd24);
    wait_load_m(cyc, bok);
    checks++; begin logic [2*N-1:0] e; e = pop_exp(); if (m !== e) begin errors++; $display("FAIL to_pre_m got %0h want %0h", m, e); end end
    tick();
    mdl_en = 1'b0;
    key(4'h1); key(4'h2); key(4'hE);
    tick();
    hit = 0;
    saw_load_m = 1'b0;
    for (int i = 1; i <= 2 * TIMEOUT; i++) begin
      tick();
      if (load_m) saw_load_m = 1'b1;
      if (err) begin
        hit = i;
        break;
      end
    end
    checks++; if (hit != TIMEOUT) begin errors++; $display("FAIL to_err_time got %0d want %0d", hit, TIMEOUT); end
    checks++; if (saw_load_m || m !== 8'd24 || busy !== 1'b0) begin errors++; $display("FAIL to_state got load_m=%0b m=%0h busy=%0b want 0/18/0", saw_load_m, m, busy); end
    key(4'h5);
    checks++; if (load_a !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL to_get_a got load_a=%0b err=%0b want 1/1", load_a, err); end
    key(4'hF);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_clear got %0b want 0", err); end
    mdl_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_basic();
    test_clear();
    test_wait_keys();
    test_back_to_back();
    test_reset_wait();
`ifdef CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
